// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall patterns, reset level, bus width, FSM encoding.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    localparam int REG_BUS = 32;
    typedef logic [REG_BUS-1:0] reg_bus_t;

    localparam logic     RST_ENABLE = 1'b1;
    localparam reg_bus_t ZERO_WORD  = '0;

    // A set stall bit freezes that pipeline register.
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit order: {WB, MEM, EX, ID, IF, PC}. Each pattern freezes everything up to
    // and including the requesting stage; the next register downstream bubbles.
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_IF   = {NO_STOP, NO_STOP, NO_STOP, NO_STOP, STOP, STOP};
    localparam logic [5:0] STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
    localparam logic [5:0] STALL_EX   = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};
    localparam logic [5:0] STALL_MEM  = {NO_STOP, STOP, STOP, STOP, STOP, STOP};

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // The most downstream requester decides the pattern.
    function automatic logic [5:0] stall_pattern(input logic req_if, input logic req_id,
                                                 input logic req_ex, input logic req_mem);
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of stall requests, exception commit and sequencer outputs for pipe_ctrl.
// Latency: n/a (wires only).
// Backpressure: n/a; master = pipeline stages, slave = sequencer.
// Signals: stallreq_{if,id,ex,mem}, excp_valid, excp_eret, epc (to sequencer);
//          stall, flush, new_pc, stall_timeout, stall_cycles (from sequencer).
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        excp_valid;
    logic        excp_eret;
    reg_bus_t    epc;
    logic [5:0]  stall;
    logic        flush;
    reg_bus_t    new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_eret, epc,
        input  stall, flush, new_pc, stall_timeout, stall_cycles
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_eret, epc,
        output stall, flush, new_pc, stall_timeout, stall_cycles
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects inc/clr one cycle later.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst (sync, active high), inc, clr (wins over inc), count.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clr) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + ONE;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, drives flush/redirect on exception or ERET.
// Latency: stall/flush/new_pc are same-cycle from inputs; watchdog and perf counter lag one cycle.
// Backpressure: exceptions override stalls; requests are ignored while a flush is in progress.
// Ports: clk, rst (sync, active high), bus (pipe_ctrl_if.slave).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter reg_bus_t    EXCP_VECTOR  = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [15:0] WDT_LIMIT    = 16'd1024
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [3:0]  flush_cnt;
    reg_bus_t    pc_q;
    logic        timeout_q;
    logic [15:0] consec;
    logic [31:0] perf_cnt;

    logic        in_rst;
    reg_bus_t    excp_target;
    logic [5:0]  stall_c;
    logic        flush_c;
    reg_bus_t    new_pc_c;
    logic        stall_any;

    assign in_rst      = (rst == RST_ENABLE);
    assign excp_target = bus.excp_eret ? bus.epc : EXCP_VECTOR;

    // Requesters must freeze in the same cycle, so outputs are combinational.
    // Reset gates them so a flush in progress is abandoned immediately.
    always_comb begin
        stall_c  = STALL_NONE;
        flush_c  = 1'b0;
        new_pc_c = pc_q;
        if (in_rst) begin
            new_pc_c = ZERO_WORD;
        end else if (state == ST_FLUSH) begin
            flush_c = 1'b1;
        end else if (bus.excp_valid) begin
            flush_c  = 1'b1;
            new_pc_c = excp_target;
        end else begin
            stall_c = stall_pattern(bus.stallreq_if, bus.stallreq_id,
                                    bus.stallreq_ex, bus.stallreq_mem);
        end
    end

    always_ff @(posedge clk) begin
        if (in_rst) begin
            state     <= ST_RUN;
            flush_cnt <= 4'd0;
            pc_q      <= ZERO_WORD;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.excp_valid) begin
                        pc_q <= excp_target;
                        if (FLUSH_CYCLES > 1) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FLUSH_RELOAD;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (bus.excp_valid) begin
                        // Latest event wins and restarts the flush window.
                        pc_q <= excp_target;
                        if (FLUSH_CYCLES > 1) begin
                            flush_cnt <= FLUSH_RELOAD;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else if (flush_cnt <= 4'd1) begin
                        state <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign stall_any = (stall_c != STALL_NONE);

    sat_counter #(.WIDTH(16)) u_wdt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_any),
        .clr   (!stall_any || flush_c),
        .count (consec)
    );

    sat_counter #(.WIDTH(32)) u_perf (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_any),
        .clr   (1'b0),
        .count (perf_cnt)
    );

    // consec counts prior stalled cycles, so hitting LIMIT-1 on a stalled
    // cycle means this is the LIMIT-th consecutive one.
    always_ff @(posedge clk) begin
        if (in_rst) begin
            timeout_q <= 1'b0;
        end else if (stall_any && (consec >= WDT_LIMIT - 16'd1)) begin
            timeout_q <= 1'b1;
        end
    end

    assign bus.stall         = stall_c;
    assign bus.flush         = flush_c;
    assign bus.new_pc        = new_pc_c;
    assign bus.stall_timeout = timeout_q;
    assign bus.stall_cycles  = perf_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (1-cycle and 3-cycle flush, watchdog limit 8) share stimulus.
// Latency: expectations for combinational outputs are taken mid-cycle, registered ones lag an edge.
// Backpressure: n/a.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [31:0] EXCP = 32'h0000_0020;
    localparam int          WDT  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if if1();
    pipe_ctrl_if if3();

    pipe_ctrl #(.EXCP_VECTOR(EXCP), .FLUSH_CYCLES(1), .WDT_LIMIT(16'd8)) dut1 (
        .clk(clk), .rst(rst), .bus(if1));
    pipe_ctrl #(.EXCP_VECTOR(EXCP), .FLUSH_CYCLES(3), .WDT_LIMIT(16'd8)) dut3 (
        .clk(clk), .rst(rst), .bus(if3));

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: remaining flush cycles, redirect target, run length of stalls.
    int          rem   [2] = '{0, 0};
    logic [31:0] tgt   [2] = '{32'd0, 32'd0};
    int          run   [2] = '{0, 0};
    logic        to_m  [2] = '{1'b0, 1'b0};
    logic [31:0] cyc   [2] = '{32'd0, 32'd0};

    logic [5:0]  exp_stall [2];
    logic        exp_flush [2];
    logic [31:0] exp_pc    [2];
    logic        exp_to    [2];
    logic [31:0] exp_cyc   [2];
    logic [5:0]  obs_stall [2];
    logic        obs_flush [2];
    logic [31:0] obs_pc    [2];
    logic        obs_to    [2];
    logic [31:0] obs_cyc   [2];

    logic        cur_v;
    logic        cur_e;
    logic [31:0] cur_p;

    function automatic int flush_len(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Drive inputs, then at the falling edge compute expectations and sample outputs.
    task automatic apply(input logic r, input logic [3:0] rq, input logic v,
                         input logic e, input logic [31:0] p);
        int hi;
        rst = r; cur_v = v; cur_e = e; cur_p = p;
        if1.stallreq_if = rq[0]; if1.stallreq_id = rq[1];
        if1.stallreq_ex = rq[2]; if1.stallreq_mem = rq[3];
        if1.excp_valid = v; if1.excp_eret = e; if1.epc = p;
        if3.stallreq_if = rq[0]; if3.stallreq_id = rq[1];
        if3.stallreq_ex = rq[2]; if3.stallreq_mem = rq[3];
        if3.excp_valid = v; if3.excp_eret = e; if3.epc = p;
        @(negedge clk);
        hi = -1;
        for (int k = 0; k < 4; k++) if (rq[k]) hi = k;
        for (int d = 0; d < 2; d++) begin
            exp_stall[d] = 6'd0;
            exp_flush[d] = 1'b0;
            exp_pc[d]    = tgt[d];
            if (r) begin
                exp_pc[d] = 32'd0;
            end else if (rem[d] > 0) begin
                exp_flush[d] = 1'b1;
            end else if (v) begin
                exp_flush[d] = 1'b1;
                exp_pc[d]    = e ? p : EXCP;
            end else if (hi >= 0) begin
                exp_stall[d] = 6'((1 << (hi + 2)) - 1);
            end
            exp_to[d]  = to_m[d];
            exp_cyc[d] = cyc[d];
        end
        obs_stall[0] = if1.stall;  obs_stall[1] = if3.stall;
        obs_flush[0] = if1.flush;  obs_flush[1] = if3.flush;
        obs_pc[0]    = if1.new_pc; obs_pc[1]    = if3.new_pc;
        obs_to[0]    = if1.stall_timeout; obs_to[1] = if3.stall_timeout;
        obs_cyc[0]   = if1.stall_cycles;  obs_cyc[1] = if3.stall_cycles;
    endtask

    // Clock edge: advance the model.
    task automatic advance();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rem[d] = 0; tgt[d] = 32'd0; run[d] = 0; to_m[d] = 1'b0; cyc[d] = 32'd0;
            end else begin
                if (cur_v) begin
                    tgt[d] = cur_e ? cur_p : EXCP;
                    rem[d] = flush_len(d) - 1;
                end else if (rem[d] > 0) begin
                    rem[d] = rem[d] - 1;
                end
                if (exp_stall[d] != 6'd0) begin
                    if (run[d] >= WDT - 1) to_m[d] = 1'b1;
                    if (run[d] < 65535) run[d] = run[d] + 1;
                    if (cyc[d] != 32'hFFFF_FFFF) cyc[d] = cyc[d] + 32'd1;
                end else begin
                    run[d] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 4'hF, 1'b0, 1'b0, 32'd0);
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_stall[d] !== 6'd0) begin
                    miscompares++; $display("FAIL reset_stall dut%0d got %b want 000000", d, obs_stall[d]);
                end
                vectors++;
                if (obs_flush[d] !== 1'b0) begin
                    miscompares++; $display("FAIL reset_flush dut%0d got %b want 0", d, obs_flush[d]);
                end
                vectors++;
                if (obs_pc[d] !== 32'd0) begin
                    miscompares++; $display("FAIL reset_new_pc dut%0d got %h want 0", d, obs_pc[d]);
                end
                if (i > 0) begin
                    vectors++;
                    if (obs_cyc[d] !== 32'd0 || obs_to[d] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL reset_counters dut%0d got cyc=%h to=%b want 0/0", d, obs_cyc[d], obs_to[d]);
                    end
                end
            end
            advance();
        end
        apply(1'b0, 4'h0, 1'b0, 1'b0, 32'd0);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_stall[d] !== 6'd0 || obs_cyc[d] !== 32'd0 || obs_to[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset dut%0d got stall=%b cyc=%h to=%b", d, obs_stall[d], obs_cyc[d], obs_to[d]);
            end
        end
        advance();
    endtask

    task automatic test_stall_priority();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 4'b0110, 1'b0, 1'b0, 32'd0);
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_stall[d] !== exp_stall[d]) begin
                    miscompares++; $display("FAIL id_ex_stall dut%0d got %b want %b", d, obs_stall[d], exp_stall[d]);
                end
            end
            advance();
        end
        apply(1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (obs_stall[d] !== exp_stall[d]) begin
                miscompares++; $display("FAIL release_stall dut%0d got %b want %b", d, obs_stall[d], exp_stall[d]);
            end
            vectors++;
            if (obs_cyc[d] !== exp_cyc[d]) begin
                miscompares++; $display("FAIL stall_cycles_4 dut%0d got %0d want %0d", d, obs_cyc[d], exp_cyc[d]);
            end
        end
        advance();
    endtask

    task automatic test_excp_over_stall();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 4'b1000, (i == 0), 1'b0, 32'hDEAD_BEEF);
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_flush[d] !== exp_flush[d] || obs_stall[d] !== exp_stall[d]) begin
                    miscompares++;
                    $display("FAIL excp_flush_stall dut%0d cyc%0d got %b/%b want %b/%b", d, i,
                             obs_flush[d], obs_stall[d], exp_flush[d], exp_stall[d]);
                end
                vectors++;
                if (obs_pc[d] !== exp_pc[d]) begin
                    miscompares++; $display("FAIL excp_new_pc dut%0d cyc%0d got %h want %h", d, i, obs_pc[d], exp_pc[d]);
                end
            end
            advance();
        end
    endtask

    task automatic test_eret_reflush();
        int nflush;
        nflush = 0;
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 4'b0000, (i < 2), (i == 0), 32'h8000_1234);
            if (obs_flush[1] === 1'b1) nflush++;
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_flush[d] !== exp_flush[d] || obs_stall[d] !== exp_stall[d]) begin
                    miscompares++;
                    $display("FAIL eret_flush dut%0d cyc%0d got %b/%b want %b/%b", d, i,
                             obs_flush[d], obs_stall[d], exp_flush[d], exp_stall[d]);
                end
                vectors++;
                if (obs_pc[d] !== exp_pc[d]) begin
                    miscompares++; $display("FAIL eret_new_pc dut%0d cyc%0d got %h want %h", d, i, obs_pc[d], exp_pc[d]);
                end
            end
            advance();
        end
        vectors++;
        if (nflush != 4) begin
            miscompares++; $display("FAIL eret_flush_len got %0d cycles want 4", nflush);
        end
    endtask

    task automatic test_watchdog();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 7 + pass; i++) begin
                apply(1'b0, 4'b0001, 1'b0, 1'b0, 32'd0);
                advance();
            end
            for (int i = 0; i < 3; i++) begin
                apply(1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
                for (int d = 0; d < 2; d++) begin
                    vectors++;
                    if (obs_to[d] !== exp_to[d]) begin
                        miscompares++;
                        $display("FAIL wdt_hold%0d dut%0d got %b want %b", 7 + pass, d, obs_to[d], exp_to[d]);
                    end
                end
                advance();
            end
        end
        vectors++;
        if (if1.stall_timeout !== 1'b1) begin
            miscompares++; $display("FAIL wdt_sticky got %b want 1", if1.stall_timeout);
        end
    endtask

    task automatic test_saturation();
        force dut1.u_perf.count_q = 32'hFFFF_FFFE;
        force dut3.u_perf.count_q = 32'hFFFF_FFFE;
        #1;
        release dut1.u_perf.count_q;
        release dut3.u_perf.count_q;
        cyc[0] = 32'hFFFF_FFFE;
        cyc[1] = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, (i < 3) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 32'd0);
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_cyc[d] !== exp_cyc[d]) begin
                    miscompares++; $display("FAIL perf_saturate dut%0d cyc%0d got %h want %h", d, i, obs_cyc[d], exp_cyc[d]);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        apply(1'b1, 4'h0, 1'b0, 1'b0, 32'd0);
        advance();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 63) == 0), 4'($urandom), ($urandom_range(0, 7) == 0),
                  1'($urandom), $urandom);
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (obs_stall[d] !== exp_stall[d] || obs_flush[d] !== exp_flush[d] || obs_pc[d] !== exp_pc[d]) begin
                    miscompares++;
                    $display("FAIL rand_comb dut%0d it%0d got %b/%b/%h want %b/%b/%h", d, i,
                             obs_stall[d], obs_flush[d], obs_pc[d], exp_stall[d], exp_flush[d], exp_pc[d]);
                end
                vectors++;
                if (obs_to[d] !== exp_to[d] || obs_cyc[d] !== exp_cyc[d]) begin
                    miscompares++;
                    $display("FAIL rand_regs dut%0d it%0d got to=%b cyc=%h want to=%b cyc=%h", d, i,
                             obs_to[d], obs_cyc[d], exp_to[d], exp_cyc[d]);
                end
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stall_priority();
        test_excp_over_stall();
        test_eret_reflush();
        test_watchdog();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and generates the pipeline flush and redirect PC on exception or ERET. It also tracks stall behaviour through a consecutive-stall watchdog and a saturating performance counter.

Parameters:
EXCP_VECTOR, 32'h0000_0020, redirect PC for exceptions.
FLUSH_CYCLES, 1, number of cycles `flush` is held per event; legal range 1..15.
WDT_LIMIT, 16'd1024, consecutive stall cycles that raise `stall_timeout`.

Ports:
clk  in  1  core clock.
rst  in  1  synchronous, active-high reset (`RstEnable`).
stallreq_if  in  1  instruction bus busy.
stallreq_id  in  1  load-use hazard.
stallreq_ex  in  1  multi-cycle EX operation (mult/div) busy.
stallreq_mem  in  1  data bus busy.
excp_valid_i  in  1  MEM-stage exception or ERET commit request.
excp_eret_i  in  1  qualifies excp_valid_i as ERET.
epc_i  in  32  return PC for ERET.
stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; `Stop`=1.
flush  out  1  clear all pipeline registers.
new_pc  out  32  redirect target, valid while flush=1.
stall_timeout  out  1  sticky watchdog flag.
stall_cycles  out  32  saturating count of cycles with stall≠0.

Behaviour:
- Reset: stall=6'b000000, flush=0, new_pc=`ZeroWord`, stall_timeout=0, stall_cycles=0, FSM=RUN, counters cleared. Reset mid-flush aborts the flush immediately.
- stall and flush are combinational from the current inputs and the registered state. There is zero-cycle latency, because requesters must freeze the same cycle.
- Stall priority (highest stage wins):
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- Each pattern freezes all stages up to and including the requester. The next register downstream inserts a bubble (stall[n]=Stop, stall[n+1]=NoStop).
- FSM states are RUN and FLUSH.
- RUN with excp_valid_i=1:
  - flush=1 and stall=0 the same cycle.
  - new_pc = excp_eret_i ? epc_i : EXCP_VECTOR.
  - new_pc is latched into pc_q.
  - If FLUSH_CYCLES>1, go to FLUSH with flush_cnt=FLUSH_CYCLES-1.
- FLUSH:
  - flush=1, stall=0, new_pc=pc_q, and all stall requests are ignored.
  - flush_cnt decrements each cycle; at 1, return to RUN.
  - A new excp_valid_i in FLUSH relatches the target (latest wins) and reloads flush_cnt=FLUSH_CYCLES-1, or returns to RUN if FLUSH_CYCLES==1.
- Exception takes priority over any simultaneous stall request.
- new_pc holds its last value when flush=0.
- Watchdog:
  - 16-bit consec_cnt increments on every cycle with stall≠0 and clears on any cycle with stall=0 or flush=1.
  - When consec_cnt reaches WDT_LIMIT-1 while stall≠0, stall_timeout sets on the next edge and stays set until rst.
  - consec_cnt saturates rather than wrapping.
- stall_cycles increments on every cycle with stall≠0 and saturates at 32'hFFFF_FFFF without wrapping.

Decomposition:
- Shared define package holds:
  - stall pattern constants (STALL_NONE/IF/ID/EX/MEM)
  - `Stop`/`NoStop`
  - `RstEnable`
  - `ZeroWord`
  - `RegBus`
  - the FSM state encoding
- One natural sub-module, sat_counter (parameterised width, inc, clr, saturating), is instantiated for both the watchdog and the perf counter.

Test Plan:
- Reset held 3 cycles with all requests=1 → stall=0, flush=0, new_pc=0, stall_cycles=0.
- Assert stallreq_id and stallreq_ex together for 4 cycles → stall=6'b001111 each cycle; stall_cycles=4; release → stall=0 the same cycle.
- Raise excp_valid_i=1, eret=0 together with stallreq_mem=1, FLUSH_CYCLES=1 → flush=1, stall=0, new_pc=32'h20 for exactly 1 cycle, then stall=6'b011111.
- ERET with epc_i=32'h8000_1234, FLUSH_CYCLES=3; second exception (eret=0) in flush cycle 2:
  - flush is high for 1+3 cycles.
  - new_pc reads 0x80001234, then 0x20.
- WDT_LIMIT=8, stallreq_if held 7 cycles → no timeout; held 8 cycles → stall_timeout=1 on the next edge; drop the request → still 1 until rst.
- Preload stall_cycles near max via a long stall (force/backdoor to 32'hFFFF_FFFE), then 3 stall cycles → reads 32'hFFFF_FFFF with no wrap.
